seven_seg_scanner: RTL

//  Time-multiplexed 4-digit seven-segment driver for the Basys3 display. Sits directly downstream of the

---
 rtl/seven_seg_scanner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver (Basys3 style, active-low pins).
// Scans digits 0..3, one digit per REFRESH_DIV-cycle slot. Each slot starts with
// BLANK_CYCLES of dead time. All inputs are captured together once per frame, so a
// frame never mixes old and new digits. All pin outputs are registered.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_mask,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned      CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  // Scan position
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  // Frame snapshot
  logic [3:0][3:0]  r_digits;
  logic [3:0]       r_dp_mask;
  logic             r_blank_lead;

  // Registered pin drivers
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_tick;

  logic             w_wrap;
  logic             w_frame_end;
  logic             w_dead;
  logic [3:0]       w_zero;
  logic [3:0]       w_blank;
  logic [6:0]       w_hex;

  // Active-low {g,f,e,d,c,b,a} hex font
  function automatic logic [6:0] hex_decode(input logic [3:0] val);
    logic [6:0] segs;
    unique case (val)
      4'h0: segs = 7'b1000000;
      4'h1: segs = 7'b1111001;
      4'h2: segs = 7'b0100100;
      4'h3: segs = 7'b0110000;
      4'h4: segs = 7'b0011001;
      4'h5: segs = 7'b0010010;
      4'h6: segs = 7'b0000010;
      4'h7: segs = 7'b1111000;
      4'h8: segs = 7'b0000000;
      4'h9: segs = 7'b0010000;
      4'hA: segs = 7'b0001000;
      4'hB: segs = 7'b0000011;
      4'hC: segs = 7'b1000110;
      4'hD: segs = 7'b0100001;
      4'hE: segs = 7'b0000110;
      4'hF: segs = 7'b0001110;
      default: segs = 7'h7F;
    endcase
    return segs;
  endfunction

  // Slot/frame boundaries and per-digit blanking derived from the snapshot
  always_comb begin
    w_wrap      = (r_cnt == CNT_MAX);
    w_frame_end = w_wrap && (r_idx == 2'd3);
    w_dead      = (r_cnt < BLANK_LIM);
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (r_digits[k] == 4'h0);
    end
    // A digit blanks only if it and every digit to its left are zero; digit 0 never blanks
    w_blank[3] = r_blank_lead & w_zero[3];
    w_blank[2] = w_blank[3] & w_zero[2];
    w_blank[1] = w_blank[2] & w_zero[1];
    w_blank[0] = 1'b0;
    w_hex      = hex_decode(r_digits[r_idx]);
  end

  // Prescaler and digit index: cnt wraps every REFRESH_DIV cycles, idx advances on wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Snapshot capture on the last cycle of the frame so the next frame is coherent
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits     <= '0;
      r_dp_mask    <= 4'h0;
      // The post-reset frame shows all-zero digits as a single "0"
      r_blank_lead <= 1'b1;
    end else if (w_frame_end) begin
      r_digits     <= {thousands, hundreds, tens, ones};
      r_dp_mask    <= dp_mask;
      r_blank_lead <= blank_lead;
    end
  end

  // Pin drivers: one cycle behind cnt/idx/snapshot; dead time forces everything off
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_dead) begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_blank[r_idx] ? 7'h7F : w_hex;
        r_dp  <= ~r_dp_mask[r_idx];
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
